// File: rtl/display_write_scheduler_pkg.sv
// Shared constants and types for the display SPI write path.
// Frame layout: {CMD_WRITE, addr[3:0], data[7:0]}, sent MSB first.
package display_spi_pkg;

    localparam logic [3:0]  CMD_WRITE = 4'b0001;
    localparam int unsigned FRAME_W   = 16;

    localparam logic [3:0] REG_ENABLE = 4'd0;
    localparam logic [3:0] REG_DIGIT1 = 4'd1;
    localparam logic [3:0] REG_DIGIT2 = 4'd2;
    localparam logic [3:0] REG_DIGIT3 = 4'd3;
    localparam logic [3:0] REG_DIGIT4 = 4'd4;
    localparam logic [3:0] REG_DIGIT5 = 4'd5;
    localparam logic [3:0] REG_DIGIT6 = 4'd6;
    localparam logic [3:0] REG_DIGIT7 = 4'd7;
    localparam logic [3:0] REG_DIGIT8 = 4'd8;
    localparam logic [3:0] REG_RADIX  = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_TRAIL,
        ST_GAP
    } sched_state_e;

    function automatic logic [FRAME_W-1:0] make_frame(input logic [3:0] addr,
                                                      input logic [7:0] data);
        return {CMD_WRITE, addr, data};
    endfunction

endpackage

// File: rtl/display_write_scheduler_if.sv
// Write-request bus between the two on-chip requesters and the scheduler.
// The requester side holds valid/addr/data until it sees its ready.
interface display_write_scheduler_if;

    logic       a_valid_i;
    logic [3:0] a_addr_i;
    logic [7:0] a_data_i;
    logic       a_ready_o;

    logic       b_valid_i;
    logic [3:0] b_addr_i;
    logic [7:0] b_data_i;
    logic       b_ready_o;

    modport master (
        output a_valid_i, a_addr_i, a_data_i,
        output b_valid_i, b_addr_i, b_data_i,
        input  a_ready_o, b_ready_o
    );

    modport slave (
        input  a_valid_i, a_addr_i, a_data_i,
        input  b_valid_i, b_addr_i, b_data_i,
        output a_ready_o, b_ready_o
    );

endinterface

// File: rtl/display_rr_arbiter.sv
// Two-way round-robin accept logic; prio_i selects the favoured requester
// (0 = A, 1 = B) when both are valid. Purely combinational.
module display_rr_arbiter (
    input  logic a_valid_i,
    input  logic b_valid_i,
    input  logic prio_i,
    input  logic idle_i,
    output logic a_ready_o,
    output logic b_ready_o,
    output logic grant_o
);

    always_comb begin
        a_ready_o = idle_i & a_valid_i & (~prio_i | ~b_valid_i);
        b_ready_o = idle_i & b_valid_i & ( prio_i | ~a_valid_i);
        grant_o   = b_ready_o;
    end

endmodule

// File: rtl/display_write_scheduler.sv
// Arbitrates display register writes from two requesters and serialises each
// accepted write as one 16-bit SPI frame with registered SPI outputs.
module display_write_scheduler
    import display_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic                        clock_5meg_i,
    input  logic                        rst_low_i,
    display_write_scheduler_if.slave    req,
    output logic                        spi_sclk_o,
    output logic                        spi_ss_o,
    output logic                        spi_mosi_o,
    output logic                        busy_o,
    output logic                        last_grant_o
);

    localparam int unsigned CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       LAST_BIT = 4'(FRAME_W - 1);

    sched_state_e        state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          bit_q, bit_d;
    logic [FRAME_W-1:0]  shreg_q, shreg_d;
    logic                prio_q, prio_d;
    logic                last_grant_q, last_grant_d;
    logic                sclk_q, sclk_d;
    logic                ss_q, ss_d;
    logic                mosi_q, mosi_d;

    logic                arb_idle;
    logic                a_ready, b_ready, grant;
    logic [3:0]          sel_addr;
    logic [7:0]          sel_data;

    // Gating with reset keeps a requester from seeing an accept that the held-in-reset flops would drop.
    assign arb_idle = (state_q == ST_IDLE) & rst_low_i;

    display_rr_arbiter u_arb (
        .a_valid_i (req.a_valid_i),
        .b_valid_i (req.b_valid_i),
        .prio_i    (prio_q),
        .idle_i    (arb_idle),
        .a_ready_o (a_ready),
        .b_ready_o (b_ready),
        .grant_o   (grant)
    );

    assign req.a_ready_o = a_ready;
    assign req.b_ready_o = b_ready;
    assign sel_addr      = grant ? req.b_addr_i : req.a_addr_i;
    assign sel_data      = grant ? req.b_data_i : req.a_data_i;

    always_ff @(posedge clock_5meg_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            prio_q       <= 1'b0;
            last_grant_q <= 1'b0;
            sclk_q       <= 1'b1;
            ss_q         <= 1'b1;
            mosi_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            prio_q       <= prio_d;
            last_grant_q <= last_grant_d;
            sclk_q       <= sclk_d;
            ss_q         <= ss_d;
            mosi_q       <= mosi_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        prio_d       = prio_q;
        last_grant_d = last_grant_q;

        case (state_q)
            ST_IDLE: begin
                if (a_ready | b_ready) begin
                    shreg_d      = make_frame(sel_addr, sel_data);
                    prio_d       = ~grant;
                    last_grant_d = grant;
                    cnt_d        = '0;
                    bit_d        = '0;
                    state_d      = ST_LEAD;
                end
            end
            ST_LEAD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (bit_q != LAST_BIT) begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = shreg_q << 1;
                        state_d = ST_SHIFT_LO;
                    end else begin
                        state_d = ST_TRAIL;
                    end
                end
            end
            ST_TRAIL: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pin levels are decoded from the next state so the pins change on the same edge as the state.
    always_comb begin
        sclk_d = 1'b1;
        ss_d   = 1'b1;
        mosi_d = 1'b1;
        case (state_d)
            ST_LEAD, ST_SHIFT_HI, ST_TRAIL: begin
                ss_d   = 1'b0;
                mosi_d = shreg_d[FRAME_W-1];
            end
            ST_SHIFT_LO: begin
                sclk_d = 1'b0;
                ss_d   = 1'b0;
                mosi_d = shreg_d[FRAME_W-1];
            end
            default: ;
        endcase
    end

    assign spi_sclk_o   = sclk_q;
    assign spi_ss_o     = ss_q;
    assign spi_mosi_o   = mosi_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign last_grant_o = last_grant_q;

endmodule

// File: doc/display_write_scheduler.md
# display_write_scheduler

Arbitrates display register writes from two on-chip requesters and serialises each granted write as one 16-bit SPI frame to the Nexys4 display receiver: command 0001, 4-bit address, 8-bit value. Sits on the host side of the SPI link, in the 5 MHz domain. Owns the only SPI master driving the display, so it guarantees correct frame alignment, bit timing and inter-frame gap.

## Interface
- CLK_DIV, 4: system cycles per SCLK half-period; minimum 2.
- GAP_CYCLES, 8: cycles SS stays high between frames; minimum 2.
- clock_5meg_i  in  1  system clock, 5 MHz, rising edge.
- rst_low_i  in  1  asynchronous, active-low reset.
- a_valid_i  in  1  requester A has a write pending; holds until accepted.
- a_addr_i  in  4  requester A register address.
- a_data_i  in  8  requester A register value.
- a_ready_o  out  1  requester A write accepted this cycle.
- b_valid_i, b_addr_i, b_data_i, b_ready_o: same as A, for requester B.
- spi_sclk_o  out  1  SPI clock; idles high; receiver samples on the rising edge.
- spi_ss_o  out  1  slave select, active low; idles high.
- spi_mosi_o  out  1  serial data, MSB first; idles high.
- busy_o  out  1  high in every state except IDLE.
- last_grant_o  out  1  0 = A, 1 = B; the requester served most recently.

## Operation
- States: IDLE, LEAD, SHIFT_LO, SHIFT_HI, TRAIL, GAP.
- Accept (IDLE only):
  - a_ready_o = IDLE & a_valid_i & (prio==A | !b_valid_i).
  - b_ready_o = IDLE & b_valid_i & (prio==B | !a_valid_i).
  - These ready signals are combinational and mutually exclusive.
- On an accept, the block:
  - latches frame = {4'b0001, addr, data};
  - sets prio to the other requester and last_grant_o to the winner;
  - goes to LEAD.
- Reset value of prio is A.
- LEAD: ss=0, sclk=1, mosi=frame[15]; lasts CLK_DIV cycles, then SHIFT_LO.
- SHIFT_LO: sclk=0 for CLK_DIV cycles, then SHIFT_HI.
- SHIFT_HI: sclk=1 for CLK_DIV cycles. Its first cycle is the sampling edge.
- Leaving SHIFT_HI:
  - if bit index < 15: increment the index, present the next bit on mosi, go to SHIFT_LO;
  - otherwise go to TRAIL.
- mosi changes only on SCLK falling edges, never in a cycle where sclk rises.
- TRAIL: ss=0, sclk=1 for CLK_DIV cycles. Then ss=1, mosi=1, go to GAP.
- GAP: GAP_CYCLES cycles with idle levels on all SPI lines, then IDLE.
- Addresses 10-15 are transmitted unchanged. The receiver ignores them.
- Valid inputs arriving during busy are not accepted. Requesters hold them.
- Reset value of all outputs: sclk=1, ss=1, mosi=1, busy=0, last_grant=0, both ready=0.
- Reset asserted mid-frame: all outputs return to their idle levels immediately and the latched frame is discarded. The display shares rst_low_i, so its bit counter clears too.

## Timing
- All SPI outputs are registered. No combinational path from the inputs to the SPI pins.
- Accept at cycle 0 gives:
  - ss low from cycle 1 through cycle 2·CLK_DIV + 32·CLK_DIV;
  - 16 SCLK rising edges;
  - the first rising edge at cycle 1 + 2·CLK_DIV.
- With CLK_DIV=4:
  - ss low for cycles 1-136;
  - first rising edge at cycle 9;
  - ss high at cycle 137;
  - IDLE at cycle 145;
  - next accept no earlier than cycle 145.
- Sustained throughput is one write per (34·CLK_DIV + GAP_CYCLES + 1) cycles.
- Simultaneous valid on A and B: the requester selected by prio wins. The other is served in the next IDLE if it is still valid.
- The bit counter is 4 bits and does not wrap. The frame ends after exactly 16 rising edges.

## Structure
- Package display_spi_pkg holds:
  - CMD_WRITE = 4'b0001 and FRAME_W = 16;
  - register addresses REG_ENABLE=0, REG_DIGIT1..8=1..8, REG_RADIX=9;
  - the state enum.
- Sub-module display_rr_arbiter: a two-way round-robin unit.
  - Inputs: valids, prio state, idle.
  - Outputs: ready and grant index.
- The FSM, half-period counter, bit counter and shift register stay in the top module.

## Test plan
- Single write: A writes addr 1, data 0x05.
  - Bits captured on SCLK rising edges = 0x1105, MSB first.
  - ss low for exactly 136 cycles; 16 rising edges; ss then high for at least 8 cycles.
- Contention: A (addr 2, 0x0A) and B (addr 3, 0x0B) both valid in the first cycle after reset.
  - A is served first (frame 0x120A), then B (0x130B).
  - last_grant_o reads 0 then 1.
- Sustained contention: A and B continuously valid for 6 frames.
  - Grants alternate A,B,A,B,A,B.
  - Each accept is 145 cycles after the previous one.
- Reset mid-frame: rst_low_i asserted after the 7th rising edge.
  - Next cycle: sclk=1, ss=1, mosi=1, busy=0.
  - No further edges.
  - A following write of 0x10FF completes correctly.
- MOSI stability: for random addr/data, mosi never toggles in the cycle sclk rises or while sclk is high during SHIFT_HI.
- Integration with the display receiver. Writes in order:
  - enable 0xFF;
  - digits 1-8 = 1..8;
  - radix 0x01.
  - Receiver registers then hold 0xFF, 0x01-0x08, 0x01.
  - Address 12 (0xC0) leaves all registers unchanged.
